pc_channel_fifo: RTL

//  Buffered channel between the 4-bit producer and the consumer in the producer/consumer top.

---
 rtl/pc_channel_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_channel_fifo.sv
//============================================================================
// Module      : pc_channel_fifo
// Description : Buffered valid/ready channel between the 4-bit producer and
//               the consumer. Holds up to DEPTH words in order and presents
//               the head word combinationally (fall-through read).
//               Occupancy is tracked by a three-state machine
//               (EMPTY / PARTIAL / FULL); every flag decodes from that state.
// Optional    : `define PC_CHANNEL_ERR_EN adds the sticky overflow/underflow
//               outputs. The data path is identical with or without it.
// Ports       : clock      - system clock, rising edge
//               reset      - asynchronous assert, active-low
//               in_valid   - producer presents in_data
//               in_ready   - channel accepts a word (= !full)
//               in_data    - producer word
//               out_valid  - head word valid (= !empty)
//               out_ready  - consumer takes out_data this cycle
//               out_data   - head-of-queue word
//               count      - number of stored words
//               full/empty - occupancy flags
//               overflow   - (ERR_EN) sticky: in_valid seen while full
//               underflow  - (ERR_EN) sticky: out_ready seen while empty
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_channel_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4   // power of 2, at least 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef PC_CHANNEL_ERR_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_DEPTH_M1 = CW'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_push, w_pop;

  // Flags come straight from the registered state.
  assign empty     = (state_q == S_EMPTY);
  assign full      = (state_q == S_FULL);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;
  assign out_data  = mem_q[rd_ptr_q];

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_ready & out_valid;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + C_ONE;
    end else if (w_pop && !w_push) begin
      count_d = count_q - C_ONE;
    end
    case (state_q)
      S_EMPTY: begin
        if (w_push) state_d = S_PARTIAL;
      end
      S_PARTIAL: begin
        // Simultaneous push+pop keeps occupancy, so only one-sided
        // transfers can leave PARTIAL.
        if (w_push && !w_pop && count_q == C_DEPTH_M1) begin
          state_d = S_FULL;
        end else if (w_pop && !w_push && count_q == C_ONE) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) state_d = S_PARTIAL;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage is cleared on reset so out_data reads 0 before the first push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef PC_CHANNEL_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (in_valid && full)   overflow_q  <= 1'b1;
      if (out_ready && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire
